rvh_l1d_lst_wr_sched: RTL and testbench

- Single-writer scheduler for the L1D line-state table (LST) MESI write ports.
- Three requesters compete for LST MESI writes: snoop, MLFB refill and the s0 pipeline (upgrade/downgrade). This block grants one per cycle and drives the LST's s0_req and snp write ports from a registered stage.
- Also sequences a flush walk that writes INVALID (2'd0) to every set/way.
- Guarantees the LST never sees both write enables in the same cycle; the LST's shared data mux would corrupt the snoop write otherwise.

---
 rtl/rvh_l1d_lst_wr_sched.sv | 152 +++++++++++++++
 tb/tb_rvh_l1d_lst_wr_sched.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_lst_wr_sched.sv
// LST MESI write scheduler: grants one of snoop/refill/pipe per cycle (or walks a flush) and
// registers it onto the LST snp or s0_req port one cycle later; ready is withheld while flushing.
module rvh_l1d_lst_wr_sched #(
  parameter int SET_NUM      = 2,
  parameter int SET_IDX_W    = 1,
  parameter int WAY_NUM      = 4,
  parameter int WAY_IDX_W    = 2,
  parameter int STARVE_LIMIT = 8,
  parameter int STARVE_CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 snp_wr_valid_i,
  output logic                 snp_wr_ready_o,
  input  logic [SET_IDX_W-1:0] snp_wr_set_idx_i,
  input  logic [WAY_IDX_W-1:0] snp_wr_way_idx_i,
  input  logic [1:0]           snp_wr_dat_i,
  input  logic                 rfl_wr_valid_i,
  output logic                 rfl_wr_ready_o,
  input  logic [SET_IDX_W-1:0] rfl_wr_set_idx_i,
  input  logic [WAY_IDX_W-1:0] rfl_wr_way_idx_i,
  input  logic [1:0]           rfl_wr_dat_i,
  input  logic                 pip_wr_valid_i,
  output logic                 pip_wr_ready_o,
  input  logic [SET_IDX_W-1:0] pip_wr_set_idx_i,
  input  logic [WAY_IDX_W-1:0] pip_wr_way_idx_i,
  input  logic [1:0]           pip_wr_dat_i,
  input  logic                 flush_req_i,
  output logic                 flush_busy_o,
  output logic                 flush_done_o,
  output logic                 lst_mesi_wr_en_s0_req,
  output logic [SET_IDX_W-1:0] lst_mesi_wr_set_idx_s0_req,
  output logic [WAY_IDX_W-1:0] lst_mesi_wr_way_idx_s0_req,
  output logic [1:0]           lst_mesi_wr_dat_s0_req,
  output logic                 lst_mesi_wr_en_snp,
  output logic [SET_IDX_W-1:0] lst_mesi_wr_set_idx_snp,
  output logic [WAY_IDX_W-1:0] lst_mesi_wr_way_idx_snp,
  output logic [1:0]           lst_mesi_wr_dat_snp
);

  localparam int FC_W = SET_IDX_W + WAY_IDX_W + 1;
  localparam logic [FC_W-1:0] FLUSH_END  = FC_W'(SET_NUM * WAY_NUM);
  localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(SET_NUM * WAY_NUM - 1);
  localparam logic [STARVE_CNT_W-1:0] STARVE_TH = STARVE_CNT_W'(STARVE_LIMIT);

  typedef enum logic {S_RUN, S_FLUSH} state_e;

  state_e                  state_q, state_d;
  logic [FC_W-1:0]         flush_cnt_q, flush_cnt_d, flush_idx;
  logic                    flush_wr, flush_start, flush_end;
  logic [STARVE_CNT_W-1:0] starve_cnt_q;
  logic                    boost, arb_en;

  // The flush-start cycle already owns next cycle's s0 port slot, so no grant is issued then;
  // otherwise a snoop grant would land beside flush write (0,0) and break port exclusivity.
  assign flush_start = (state_q == S_RUN) && flush_req_i;
  assign arb_en      = (state_q == S_RUN) && !flush_req_i;
  assign boost       = starve_cnt_q >= STARVE_TH;

  assign snp_wr_ready_o = arb_en && snp_wr_valid_i;
  assign pip_wr_ready_o = arb_en && pip_wr_valid_i && !snp_wr_valid_i && (boost || !rfl_wr_valid_i);
  assign rfl_wr_ready_o = arb_en && rfl_wr_valid_i && !snp_wr_valid_i && !(boost && pip_wr_valid_i);

  // flush_cnt_q holds the index of the next flush write; FLUSH_END is a tail cycle with the
  // final write on the port, after which arbitration resumes.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    flush_wr    = 1'b0;
    flush_idx   = '0;
    flush_end   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (flush_req_i) begin
          state_d     = S_FLUSH;
          flush_wr    = 1'b1;
          flush_cnt_d = FC_W'(1);
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLUSH_END) begin
          state_d     = S_RUN;
          flush_end   = 1'b1;
          flush_cnt_d = '0;
        end else begin
          flush_wr    = 1'b1;
          flush_idx   = flush_cnt_q;
          flush_cnt_d = flush_cnt_q + FC_W'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_RUN;
      flush_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      if (!pip_wr_valid_i || pip_wr_ready_o) begin
        starve_cnt_q <= '0;
      end else if (starve_cnt_q != '1) begin
        starve_cnt_q <= starve_cnt_q + STARVE_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flush_busy_o               <= 1'b0;
      flush_done_o               <= 1'b0;
      lst_mesi_wr_en_s0_req      <= 1'b0;
      lst_mesi_wr_set_idx_s0_req <= '0;
      lst_mesi_wr_way_idx_s0_req <= '0;
      lst_mesi_wr_dat_s0_req     <= '0;
      lst_mesi_wr_en_snp         <= 1'b0;
      lst_mesi_wr_set_idx_snp    <= '0;
      lst_mesi_wr_way_idx_snp    <= '0;
      lst_mesi_wr_dat_snp        <= '0;
    end else begin
      if (flush_start) begin
        flush_busy_o <= 1'b1;
      end else if (flush_end) begin
        flush_busy_o <= 1'b0;
      end
      flush_done_o          <= flush_wr && (flush_idx == FLUSH_LAST);
      lst_mesi_wr_en_snp    <= snp_wr_ready_o;
      lst_mesi_wr_en_s0_req <= flush_wr || rfl_wr_ready_o || pip_wr_ready_o;
      if (snp_wr_ready_o) begin
        lst_mesi_wr_set_idx_snp <= snp_wr_set_idx_i;
        lst_mesi_wr_way_idx_snp <= snp_wr_way_idx_i;
        lst_mesi_wr_dat_snp     <= snp_wr_dat_i;
      end
      if (flush_wr) begin
        lst_mesi_wr_set_idx_s0_req <= flush_idx[WAY_IDX_W +: SET_IDX_W];
        lst_mesi_wr_way_idx_s0_req <= flush_idx[WAY_IDX_W-1:0];
        lst_mesi_wr_dat_s0_req     <= 2'd0;
      end else if (rfl_wr_ready_o) begin
        lst_mesi_wr_set_idx_s0_req <= rfl_wr_set_idx_i;
        lst_mesi_wr_way_idx_s0_req <= rfl_wr_way_idx_i;
        lst_mesi_wr_dat_s0_req     <= rfl_wr_dat_i;
      end else if (pip_wr_ready_o) begin
        lst_mesi_wr_set_idx_s0_req <= pip_wr_set_idx_i;
        lst_mesi_wr_way_idx_s0_req <= pip_wr_way_idx_i;
        lst_mesi_wr_dat_s0_req     <= pip_wr_dat_i;
      end
    end
  end

endmodule

// File: tb/tb_rvh_l1d_lst_wr_sched.sv
// Bench for rvh_l1d_lst_wr_sched: queue-based reference model checked every cycle, plus directed scenarios.
module tb_rvh_l1d_lst_wr_sched;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       snp_v = 1'b0, snp_r;
  logic       snp_set = 1'b0;
  logic [1:0] snp_way = 2'd0, snp_dat = 2'd0;
  logic       rfl_v = 1'b0, rfl_r;
  logic       rfl_set = 1'b0;
  logic [1:0] rfl_way = 2'd0, rfl_dat = 2'd0;
  logic       pip_v = 1'b0, pip_r;
  logic       pip_set = 1'b0;
  logic [1:0] pip_way = 2'd0, pip_dat = 2'd0;
  logic       flush_req = 1'b0, busy, done;
  logic       s0_en, s0_set, snp_en, snp_oset;
  logic [1:0] s0_way, s0_dat, snp_oway, snp_odat;

  int n_cmp = 0;
  int n_err = 0;

  rvh_l1d_lst_wr_sched dut (
    .clk(clk), .rstn(rstn),
    .snp_wr_valid_i(snp_v), .snp_wr_ready_o(snp_r), .snp_wr_set_idx_i(snp_set),
    .snp_wr_way_idx_i(snp_way), .snp_wr_dat_i(snp_dat),
    .rfl_wr_valid_i(rfl_v), .rfl_wr_ready_o(rfl_r), .rfl_wr_set_idx_i(rfl_set),
    .rfl_wr_way_idx_i(rfl_way), .rfl_wr_dat_i(rfl_dat),
    .pip_wr_valid_i(pip_v), .pip_wr_ready_o(pip_r), .pip_wr_set_idx_i(pip_set),
    .pip_wr_way_idx_i(pip_way), .pip_wr_dat_i(pip_dat),
    .flush_req_i(flush_req), .flush_busy_o(busy), .flush_done_o(done),
    .lst_mesi_wr_en_s0_req(s0_en), .lst_mesi_wr_set_idx_s0_req(s0_set),
    .lst_mesi_wr_way_idx_s0_req(s0_way), .lst_mesi_wr_dat_s0_req(s0_dat),
    .lst_mesi_wr_en_snp(snp_en), .lst_mesi_wr_set_idx_snp(snp_oset),
    .lst_mesi_wr_way_idx_snp(snp_oway), .lst_mesi_wr_dat_snp(snp_odat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: expected port contents for the current cycle, flush writes still to come,
  // and how many consecutive cycles the pipe requester has waited.
  logic       e_s0_en = 0, e_s0_set = 0, e_snp_en = 0, e_snp_set = 0, e_busy = 0, e_done = 0;
  logic [1:0] e_s0_way = 0, e_s0_dat = 0, e_snp_way = 0, e_snp_dat = 0;
  int         m_q[$];
  int         m_wait = 0;

  initial begin : model_cmp
    bit allow, gs, gr, gp;
    int idx;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        e_s0_en = 0; e_s0_set = 0; e_s0_way = 0; e_s0_dat = 0;
        e_snp_en = 0; e_snp_set = 0; e_snp_way = 0; e_snp_dat = 0;
        e_busy = 0; e_done = 0; m_q.delete(); m_wait = 0;
      end else begin
        chk("s0_en", s0_en, e_s0_en);
        chk("s0_set", s0_set, e_s0_set);
        chk("s0_way", s0_way, e_s0_way);
        chk("s0_dat", s0_dat, e_s0_dat);
        chk("snp_en", snp_en, e_snp_en);
        chk("snp_set", snp_oset, e_snp_set);
        chk("snp_way", snp_oway, e_snp_way);
        chk("snp_dat", snp_odat, e_snp_dat);
        chk("busy", busy, e_busy);
        chk("done", done, e_done);
        chk("en_excl", s0_en & snp_en, 0);
        allow = !e_busy && !flush_req;
        gs = allow && snp_v;
        gp = allow && pip_v && !snp_v && (m_wait >= 8 || !rfl_v);
        gr = allow && rfl_v && !snp_v && !gp;
        chk("snp_rdy", snp_r, gs);
        chk("rfl_rdy", rfl_r, gr);
        chk("pip_rdy", pip_r, gp);
        if (!e_busy && flush_req)
          for (int i = 0; i < 8; i++) m_q.push_back(i);
        e_s0_en = 0; e_snp_en = 0; e_busy = 0; e_done = 0;
        if (m_q.size() > 0) begin
          idx = m_q.pop_front();
          e_s0_en = 1; e_s0_set = 1'(idx / 4); e_s0_way = 2'(idx % 4); e_s0_dat = 2'd0;
          e_busy = 1; e_done = (m_q.size() == 0);
        end else if (gs) begin
          e_snp_en = 1; e_snp_set = snp_set; e_snp_way = snp_way; e_snp_dat = snp_dat;
        end else if (gr) begin
          e_s0_en = 1; e_s0_set = rfl_set; e_s0_way = rfl_way; e_s0_dat = rfl_dat;
        end else if (gp) begin
          e_s0_en = 1; e_s0_set = pip_set; e_s0_way = pip_way; e_s0_dat = pip_dat;
        end
        if (pip_v && !gp) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
        else m_wait = 0;
      end
    end
  end

  task automatic traffic(input int n, input bit gen);
    bit fs, fr, fp;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      fs = snp_v && snp_r; fr = rfl_v && rfl_r; fp = pip_v && pip_r;
      cyc();
      if (!snp_v || fs) begin
        snp_v = gen && ($urandom_range(0, 3) == 0);
        snp_set = 1'($urandom_range(0, 1)); snp_way = 2'($urandom_range(0, 3)); snp_dat = 2'($urandom_range(0, 3));
      end
      if (!rfl_v || fr) begin
        rfl_v = gen && ($urandom_range(0, 3) != 0);
        rfl_set = 1'($urandom_range(0, 1)); rfl_way = 2'($urandom_range(0, 3)); rfl_dat = 2'($urandom_range(0, 3));
      end
      if (!pip_v || fp) begin
        pip_v = gen && ($urandom_range(0, 1) == 0);
        pip_set = 1'($urandom_range(0, 1)); pip_way = 2'($urandom_range(0, 3)); pip_dat = 2'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin : timeout
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin : main
    int waits;
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s0_en", s0_en, 0);
    chk("rst_snp_en", snp_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rstn = 1'b1;
    repeat (3) cyc();
    chk("idle_s0_en", s0_en, 0);

    // All three requesters at once: snoop, then refill, then pipe
    snp_v = 1; snp_set = 1; snp_way = 2; snp_dat = 3;
    rfl_v = 1; rfl_set = 0; rfl_way = 1; rfl_dat = 2;
    pip_v = 1; pip_set = 1; pip_way = 0; pip_dat = 1;
    @(negedge clk);
    chk("t2_snp_rdy", snp_r, 1);
    chk("t2_rfl_rdy", rfl_r, 0);
    cyc(); snp_v = 0;
    @(negedge clk);
    chk("t2_rfl_rdy1", rfl_r, 1);
    chk("t2_snp_port", {snp_en, snp_oset, snp_oway, snp_odat}, {1'b1, 1'b1, 2'd2, 2'd3});
    cyc(); rfl_v = 0;
    @(negedge clk);
    chk("t2_pip_rdy", pip_r, 1);
    chk("t2_rfl_port", {s0_en, s0_set, s0_way, s0_dat}, {1'b1, 1'b0, 2'd1, 2'd2});
    cyc(); pip_v = 0;
    @(negedge clk);
    chk("t2_pip_port", {s0_en, s0_set, s0_way, s0_dat}, {1'b1, 1'b1, 2'd0, 2'd1});
    cyc();

    // Pipe starvation under continuous refill traffic
    rfl_v = 1; rfl_set = 0; rfl_way = 0; rfl_dat = 1;
    pip_v = 1; pip_set = 1; pip_way = 3; pip_dat = 3;
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pip_r) break;
      waits++;
      cyc();
      rfl_way = 2'($urandom_range(0, 3));
    end
    chk("t3_wait", waits, 8);
    chk("t3_rfl_blocked", rfl_r, 0);
    cyc(); pip_v = 0; rfl_v = 0;
    @(negedge clk);
    chk("t3_pip_port", {s0_en, s0_set, s0_way, s0_dat}, {1'b1, 1'b1, 2'd3, 2'd3});
    cyc(); rfl_v = 1; pip_v = 1;
    @(negedge clk);
    chk("t3_cleared", rfl_r, 1);
    cyc(); rfl_v = 0;
    @(negedge clk);
    cyc(); pip_v = 0;
    cyc();

    // Flush walk with a pipe request raised during it
    flush_req = 1;
    cyc(); flush_req = 0;
    pip_v = 1; pip_set = 0; pip_way = 2; pip_dat = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("fl_port", {s0_en, s0_set, s0_way, s0_dat}, {1'b1, 1'(k / 4), 2'(k % 4), 2'd0});
      chk("fl_busy", busy, 1);
      chk("fl_done", done, (k == 7) ? 1 : 0);
      chk("fl_pip_rdy", pip_r, 0);
      cyc();
    end
    @(negedge clk);
    chk("fl_pip_after", pip_r, 1);
    chk("fl_busy_end", busy, 0);
    cyc(); pip_v = 0;
    @(negedge clk);
    chk("fl_pip_port", {s0_en, s0_set, s0_way, s0_dat}, {1'b1, 1'b0, 2'd2, 2'd1});
    cyc();

    // Snoop held across a flush
    flush_req = 1;
    cyc(); flush_req = 0;
    snp_v = 1; snp_set = 1; snp_way = 1; snp_dat = 2;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (snp_r) break;
      n++;
      cyc();
    end
    chk("t5_snp_wait", n, 8);
    cyc(); snp_v = 0;
    @(negedge clk);
    chk("t5_snp_port", {snp_en, snp_oset, snp_oway, snp_odat, s0_en}, {1'b1, 1'b1, 2'd1, 2'd2, 1'b0});
    cyc();

    // Reset in the middle of a flush walk
    flush_req = 1;
    cyc(); flush_req = 0;
    repeat (3) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("t6_s0_en", s0_en, 0);
    chk("t6_way", s0_way, 0);
    chk("t6_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (12) cyc();
    rfl_v = 1; rfl_set = 1; rfl_way = 2; rfl_dat = 1;
    @(negedge clk);
    chk("t6_rfl_rdy", rfl_r, 1);
    cyc(); rfl_v = 0;
    @(negedge clk);
    chk("t6_rfl_port", {s0_en, s0_set, s0_way, s0_dat}, {1'b1, 1'b1, 2'd2, 2'd1});
    cyc();

    // Randomized traffic with occasional flushes
    for (int b = 0; b < 8; b++) begin
      traffic(200, 1'b1);
      n = 0;
      while ((snp_v || rfl_v || pip_v) && n < 60) begin
        traffic(1, 1'b0);
        n++;
      end
      chk("drain", {29'd0, snp_v, rfl_v, pip_v}, 0);
      if (b % 2 == 0) begin
        flush_req = 1;
        cyc(); flush_req = 0;
      end
    end
    traffic(20, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
